// File: rtl/fpu_pkg.sv
// Shared FP32 field layout and operand classification for the float-to-fixed converter.
package fpu_pkg;

    localparam int FP_W     = 32;
    localparam int EXP_W    = 8;
    localparam int MANT_W   = 23;
    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;

    // Width of the signed shift amount k = exp - (bias + mant_w) + frac_w.
    localparam int K_W      = 12;

    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
    } fp_class_t;

    function automatic fp_class_t classify(input logic [EXP_W-1:0]  exp_f,
                                           input logic [MANT_W-1:0] mant_f);
        fp_class_t c;
        c.zero = (exp_f == '0);
        c.inf  = (exp_f == EXP_W'(EXP_MAX)) && (mant_f == '0);
        c.nan  = (exp_f == EXP_W'(EXP_MAX)) && (mant_f != '0);
        return c;
    endfunction

endpackage

// File: rtl/fp2fix_shift_round.sv
// Combinational shift / round / saturate of a classified FP32 mantissa into signed fixed point.
// Define FPU_FP2FIX_ROUND_EN for round-to-nearest (ties away) on right shifts; otherwise truncate.
module fp2fix_shift_round
    import fpu_pkg::*;
#(
    parameter int OUT_W = 16
) (
    input  logic                  sign,
    input  logic [MANT_W:0]       mant,
    input  logic signed [K_W-1:0] k,
    input  fp_class_t             cls,
    output logic [OUT_W-1:0]      data,
    output logic                  sat,
    output logic                  nan
);

    // Wide enough for the 24-bit mantissa shifted left by up to OUT_W.
    localparam int MW = OUT_W + MANT_W + 3;

    localparam logic [K_W-1:0]   MAX_LSH = K_W'(OUT_W);
    localparam logic [K_W-1:0]   MAX_RSH = K_W'(MANT_W + 2);
    localparam logic [MW-1:0]    NEG_LIM = MW'(1) << (OUT_W - 1);
    localparam logic [MW-1:0]    POS_LIM = NEG_LIM - MW'(1);
    localparam logic [OUT_W-1:0] POS_SAT = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] NEG_SAT = {1'b1, {(OUT_W-1){1'b0}}};

`ifdef FPU_FP2FIX_ROUND_EN
    localparam logic ROUND_EN = 1'b1;
`else
    localparam logic ROUND_EN = 1'b0;
`endif

    logic [K_W-1:0]    lsh;
    logic [K_W-1:0]    rsh;
    logic [MANT_W+1:0] rsh_bits;
    logic [MW-1:0]     mag;
    logic              huge;
    logic              over;

    assign lsh = k;
    assign rsh = -k;

    always_comb begin
        huge     = 1'b0;
        rsh_bits = '0;
        mag      = '0;
        if (!k[K_W-1]) begin
            // Any left shift beyond OUT_W overflows regardless of mantissa bits.
            huge = (lsh > MAX_LSH);
            mag  = MW'(mant) << lsh;
        end else if (rsh <= MAX_RSH) begin
            // The extra LSB catches the first discarded bit, which is the rounding bit.
            rsh_bits = {mant, 1'b0} >> rsh;
            mag      = MW'(rsh_bits[MANT_W+1:1]) + MW'(rsh_bits[0] & ROUND_EN);
        end
    end

    // A negative magnitude may reach exactly 2^(OUT_W-1) without clamping.
    assign over = huge | cls.inf | (sign ? (mag > NEG_LIM) : (mag > POS_LIM));

    always_comb begin
        data = '0;
        sat  = 1'b0;
        nan  = cls.nan;
        if (!cls.nan && !cls.zero) begin
            if (over) begin
                sat  = 1'b1;
                data = sign ? NEG_SAT : POS_SAT;
            end else begin
                data = sign ? (~mag[OUT_W-1:0] + OUT_W'(1)) : mag[OUT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fpu_fp2fix.sv
// Two-stage FP32 to signed fixed-point converter with valid/ready flow control.
// Rounding mode selected by FPU_FP2FIX_ROUND_EN (see fp2fix_shift_round).
module fpu_fp2fix
    import fpu_pkg::*;
#(
    parameter int OUT_W  = 16,
    parameter int FRAC_W = 14
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [FP_W-1:0]  i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [OUT_W-1:0] o_data,
    output logic             o_sat,
    output logic             o_nan
);

    logic                  s1_valid_reg;
    logic                  s1_sign_reg;
    logic [MANT_W:0]       s1_mant_reg;
    logic signed [K_W-1:0] s1_k_reg;
    fp_class_t             s1_cls_reg;

    logic                  out_valid_reg;
    logic [OUT_W-1:0]      out_data_reg;
    logic                  out_sat_reg;
    logic                  out_nan_reg;

    logic                  s1_advance;
    logic [EXP_W-1:0]      in_exp;
    logic [MANT_W-1:0]     in_frac;
    logic signed [K_W-1:0] in_k;
    logic [OUT_W-1:0]      data_next;
    logic                  sat_next;
    logic                  nan_next;

    assign in_exp  = i_data[FP_W-2 -: EXP_W];
    assign in_frac = i_data[MANT_W-1:0];
    // Shift that turns the 24-bit integer mantissa into a value scaled by 2^FRAC_W.
    assign in_k    = $signed(K_W'(in_exp)) - K_W'(EXP_BIAS + MANT_W) + K_W'(FRAC_W);

    assign s1_advance = ~out_valid_reg | i_ready;
    assign o_ready    = ~s1_valid_reg | s1_advance;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid_reg  <= 1'b0;
            s1_sign_reg   <= 1'b0;
            s1_mant_reg   <= '0;
            s1_k_reg      <= '0;
            s1_cls_reg    <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sat_reg   <= 1'b0;
            out_nan_reg   <= 1'b0;
        end else begin
            if (o_ready) begin
                s1_valid_reg <= i_valid;
                if (i_valid) begin
                    s1_sign_reg <= i_data[FP_W-1];
                    s1_mant_reg <= {1'b1, in_frac};
                    s1_k_reg    <= in_k;
                    s1_cls_reg  <= classify(in_exp, in_frac);
                end
            end
            if (s1_advance) begin
                out_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    out_data_reg <= data_next;
                    out_sat_reg  <= sat_next;
                    out_nan_reg  <= nan_next;
                end
            end
        end
    end

    fp2fix_shift_round #(
        .OUT_W (OUT_W)
    ) u_shift_round (
        .sign (s1_sign_reg),
        .mant (s1_mant_reg),
        .k    (s1_k_reg),
        .cls  (s1_cls_reg),
        .data (data_next),
        .sat  (sat_next),
        .nan  (nan_next)
    );

    assign o_valid = out_valid_reg;
    assign o_data  = out_data_reg;
    assign o_sat   = out_sat_reg;
    assign o_nan   = out_nan_reg;

endmodule

// File: tb/tb_fpu_fp2fix.sv
// Scoreboard bench for fpu_fp2fix: directed corner cases, stall/flush scenarios and random floats.
`timescale 1ns/1ps
module tb_fpu_fp2fix;

    localparam int OUT_W  = 16;
    localparam int FRAC_W = 14;
    localparam longint POS_MAX = (longint'(1) <<< (OUT_W - 1)) - 1;
    localparam longint NEG_MIN = -(longint'(1) <<< (OUT_W - 1));

    logic             clk     = 1'b0;
    logic             rst     = 1'b1;
    logic             i_valid = 1'b0;
    logic             i_ready = 1'b1;
    logic [31:0]      i_data  = '0;
    logic             o_ready;
    logic             o_valid;
    logic [OUT_W-1:0] o_data;
    logic             o_sat;
    logic             o_nan;

    always #5 clk = ~clk;

    fpu_fp2fix #(
        .OUT_W  (OUT_W),
        .FRAC_W (FRAC_W)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_sat   (o_sat),
        .o_nan   (o_nan)
    );

    typedef struct {
        logic [OUT_W-1:0] data;
        logic             sat;
        logic             nan;
        logic [31:0]      src;
        int               cyc;
        bit               chk_lat;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   ncyc        = 0;
    int   rdy_mode    = 0;   // 0: always ready, 1: random, 2: stalled

    always @(posedge clk) ncyc <= ncyc + 1;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       i_ready = 1'b1;
            2:       i_ready = 1'b0;
            default: i_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic check(input string name, input logic [31:0] src,
                         input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s (in=%h): got %h expected %h", name, src, act, exp_v);
        end
    endtask

    // Reference: value = mant * 2^(exp-150), scaled by 2^FRAC_W, in plain integer arithmetic.
    function automatic exp_t model(input logic [31:0] f);
        exp_t   r;
        longint mant, mag, q, v;
        int     e, k, sh;
        r.data = '0; r.sat = 1'b0; r.nan = 1'b0; r.src = f; r.cyc = 0; r.chk_lat = 1'b0;
        e    = int'(f[30:23]);
        mant = longint'({1'b1, f[22:0]});
        if (e == 255 && f[22:0] != 0) begin
            r.nan = 1'b1;
            return r;
        end
        if (e == 0) return r;
        if (e == 255) begin
            mag = longint'(1) <<< 40;
        end else begin
            k = e - 150 + FRAC_W;
            if (k > 30) mag = longint'(1) <<< 40;
            else if (k >= 0) mag = mant <<< k;
            else begin
                sh = -k;
                q  = (sh >= 40) ? 0 : (mant >>> sh);
`ifdef FPU_FP2FIX_ROUND_EN
                if (sh < 40 && 2 * (mant - (q <<< sh)) >= (longint'(1) <<< sh)) q++;
`endif
                mag = q;
            end
        end
        v = f[31] ? -mag : mag;
        if (v > POS_MAX) begin
            r.sat = 1'b1; v = POS_MAX;
        end else if (v < NEG_MIN) begin
            r.sat = 1'b1; v = NEG_MIN;
        end
        r.data = OUT_W'(v);
        return r;
    endfunction

    // Monitor: pops the scoreboard on every output handshake and checks stall stability.
    exp_t             mon_e;
    bit               hold_pend = 1'b0;
    logic [OUT_W-1:0] hold_data;
    logic             hold_sat, hold_nan;

    always @(negedge clk) begin
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", 32'h0, 32'(o_valid), 32'h1);
                check("hold_data",  32'h0, 32'(o_data),  32'(hold_data));
                check("hold_sat",   32'h0, 32'(o_sat),   32'(hold_sat));
                check("hold_nan",   32'h0, 32'(o_nan),   32'(hold_nan));
            end
            hold_pend = 1'b0;
            if (o_valid && i_ready) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_output: got data=%h expected no output", o_data);
                end else begin
                    mon_e = sb.pop_front();
                    $display("xfer in=%h data=%h sat=%b nan=%b", mon_e.src, o_data, o_sat, o_nan);
                    check("data", mon_e.src, 32'(o_data), 32'(mon_e.data));
                    check("sat",  mon_e.src, 32'(o_sat),  32'(mon_e.sat));
                    check("nan",  mon_e.src, 32'(o_nan),  32'(mon_e.nan));
                    if (mon_e.chk_lat)
                        check("latency", mon_e.src, 32'(ncyc - mon_e.cyc), 32'd2);
                end
            end else if (o_valid) begin
                hold_pend = 1'b1;
                hold_data = o_data;
                hold_sat  = o_sat;
                hold_nan  = o_nan;
            end
        end
    end

    // Presents f now and holds it until o_ready is seen, then records the expectation.
    task automatic drive_wait(input logic [31:0] f, input bit chk_lat);
        exp_t e;
        int   guard = 0;
        i_valid = 1'b1;
        i_data  = f;
        while (!o_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!o_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout (in=%h): got o_ready=0 expected 1", f);
            i_valid = 1'b0;
        end else begin
            e         = model(f);
            e.cyc     = ncyc;
            e.chk_lat = chk_lat;
            sb.push_back(e);
        end
    endtask

    task automatic send(input logic [31:0] f, input bit chk_lat);
        @(negedge clk);
        drive_wait(f, chk_lat);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            i_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 2000) begin
            idle(1);
            guard++;
        end
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    function automatic logic [31:0] rand_float();
        logic [31:0] f;
        int          sel;
        f   = $urandom;
        sel = $urandom_range(0, 19);
        case (sel)
            0:       f[30:23] = 8'h00;
            1:       f[30:0]  = {8'hFF, 23'h0};
            2: begin
                f[30:23] = 8'hFF;
                f[22:0]  = f[22:0] | 23'd1;
            end
            default: f[30:23] = 8'($urandom_range(100, 145));
        endcase
        return f;
    endfunction

    logic [31:0] directed [12] = '{
        32'hBF000000, 32'h40400000, 32'hC0000000, 32'h38000000,
        32'h00000001, 32'h7FC00000, 32'hFF800000, 32'h7F800000,
        32'h80000000, 32'hB7800000, 32'hB8000000, 32'h3FFFFFFF
    };

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_o_valid", 32'h0, 32'(o_valid), 32'h0);
        check("rst_o_data",  32'h0, 32'(o_data),  32'h0);
        check("rst_o_sat",   32'h0, 32'(o_sat),   32'h0);
        check("rst_o_nan",   32'h0, 32'(o_nan),   32'h0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_o_ready", 32'h0, 32'(o_ready), 32'h1);

        // Latency of a lone 1.0, then directed corner cases back to back.
        send(32'h3F800000, 1'b1);
        idle(4);
        foreach (directed[i]) send(directed[i], 1'b0);
        idle(1);
        drain();

        // Stall: two accepts fill the pipe, the third must wait.
        @(negedge clk);
        i_valid  = 1'b0;
        rdy_mode = 2;
        send(32'h3F800000, 1'b0);
        send(32'h3F000000, 1'b0);
        @(negedge clk);
        i_valid = 1'b1;
        i_data  = 32'h3E800000;
        check("stall_o_ready", 32'h3E800000, 32'(o_ready), 32'h0);
        repeat (2) @(negedge clk);
        check("stall_o_ready_hold", 32'h3E800000, 32'(o_ready), 32'h0);
        rdy_mode = 0;
        @(negedge clk);
        drive_wait(32'h3E800000, 1'b0);
        idle(1);
        drain();

        // Flush with both stages full and a handshake attempt on the reset edge.
        @(negedge clk);
        rdy_mode = 2;
        send(32'h3F800000, 1'b0);
        send(32'h40000000, 1'b0);
        @(negedge clk);
        rst     = 1'b1;
        i_valid = 1'b1;
        i_data  = 32'h3E000000;
        @(negedge clk);
        sb.delete();
        #1;
        check("flush_o_valid", 32'h0, 32'(o_valid), 32'h0);
        check("flush_o_data",  32'h0, 32'(o_data),  32'h0);
        check("flush_o_ready", 32'h0, 32'(o_ready), 32'h1);
        rst      = 1'b0;
        i_valid  = 1'b0;
        rdy_mode = 0;
        @(negedge clk);
        check("flush_no_stale", 32'h0, 32'(o_valid), 32'h0);
        idle(4);

        // Random floats with random gaps and backpressure.
        rdy_mode = 1;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send(rand_float(), 1'b0);
        end
        idle(1);
        drain();
        rdy_mode = 0;
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
